// File: rtl/axilite_sram_slave.sv
// AXI4-Lite slave in front of a word-organised SRAM array with byte strobes.
// Write address and data are accepted independently; reads have one cycle of array latency.
module axilite_sram_slave #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 256
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    output logic [1:0]              o_bresp,
    input  logic [ADDR_WIDTH-1:0]   i_araddr,
    input  logic                    i_arvalid,
    output logic                    o_arready,
    output logic                    o_rvalid,
    input  logic                    i_rready,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic [1:0]              o_rresp
);

    localparam int unsigned STRB = DATA_WIDTH / 8;
    localparam int unsigned OFF  = $clog2(STRB);
    localparam int unsigned IDXW = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(DEPTH * STRB);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {StIdle, StData} rstate_e;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Readies stay low for the first cycle after reset so they never depend on i_rst directly.
    logic                  r_live;
    logic                  r_aw_held;
    logic                  r_w_held;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB-1:0]       r_wstrb;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    rstate_e               r_rstate;
    rstate_e               w_rstate_next;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [STRB-1:0]       w_wstrb;
    logic [IDXW-1:0]       w_widx;
    logic [IDXW-1:0]       w_ridx;
    logic                  w_wr_ok;
    logic                  w_rd_ok;

    assign o_awready = r_live & ~r_aw_held & ~r_bvalid;
    assign o_wready  = r_live & ~r_w_held & ~r_bvalid;
    assign o_arready = r_live & (r_rstate == StIdle);
    assign o_bvalid  = r_bvalid;
    assign o_bresp   = r_bresp;
    assign o_rvalid  = (r_rstate == StData);
    assign o_rdata   = r_rdata;
    assign o_rresp   = r_rresp;

    assign w_aw_hs  = i_awvalid & o_awready;
    assign w_w_hs   = i_wvalid & o_wready;
    assign w_ar_hs  = i_arvalid & o_arready;
    assign w_commit = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
    assign w_waddr  = r_aw_held ? r_awaddr : i_awaddr;
    assign w_wdata  = r_w_held ? r_wdata : i_wdata;
    assign w_wstrb  = r_w_held ? r_wstrb : i_wstrb;
    assign w_widx   = w_waddr[OFF +: IDXW];
    assign w_ridx   = i_araddr[OFF +: IDXW];
    assign w_wr_ok  = (w_waddr < LIMIT);
    assign w_rd_ok  = (i_araddr < LIMIT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_live    <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            r_live <= 1'b1;
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (w_aw_hs) r_aw_held <= 1'b1;
                if (w_w_hs) r_w_held <= 1'b1;
                if (r_bvalid && i_bready) r_bvalid <= 1'b0;
            end
        end
    end

    // Datapath holding registers and array carry no reset.
    always_ff @(posedge i_clk) begin
        if (w_aw_hs) r_awaddr <= i_awaddr;
        if (w_w_hs) begin
            r_wdata <= i_wdata;
            r_wstrb <= i_wstrb;
        end
        if (w_commit && w_wr_ok && !i_rst) begin
            for (int i = 0; i < STRB; i++) begin
                if (w_wstrb[i]) r_mem[w_widx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_rstate_next = r_rstate;
        unique case (r_rstate)
            StIdle: if (w_ar_hs) w_rstate_next = StData;
            StData: if (i_rready) w_rstate_next = StIdle;
            default: w_rstate_next = StIdle;
        endcase
    end

    // Array read sees pre-commit contents when a write to the same word lands on this edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rstate <= StIdle;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            r_rstate <= w_rstate_next;
            if (w_ar_hs) begin
                r_rdata <= w_rd_ok ? r_mem[w_ridx] : '0;
                r_rresp <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

endmodule

// File: tb/tb_axilite_sram_slave.sv
// Directed self-checking bench for axilite_sram_slave with hand-computed expectations.
module tb_axilite_sram_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [1:0]  bresp;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axilite_sram_slave #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .DEPTH     (256)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_awaddr (awaddr),
        .i_awvalid(awvalid),
        .o_awready(awready),
        .i_wdata  (wdata),
        .i_wstrb  (wstrb),
        .i_wvalid (wvalid),
        .o_wready (wready),
        .o_bvalid (bvalid),
        .i_bready (bready),
        .o_bresp  (bresp),
        .i_araddr (araddr),
        .i_arvalid(arvalid),
        .o_arready(arready),
        .o_rvalid (rvalid),
        .i_rready (rready),
        .o_rdata  (rdata),
        .o_rresp  (rresp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_both(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              output logic [1:0] resp);
        awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        check("b_latency", 32'(bvalid), 32'd1);
        resp = bresp;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        arvalid = 1'b1; araddr = a;
        tick();
        arvalid = 1'b0;
        @(negedge clk);
        check("r_latency", 32'(rvalid), 32'd1);
        d = rdata;
        resp = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    logic [31:0] rd;
    logic [1:0]  rs;
    logic [1:0]  ws;

    initial begin
        // Reset state
        tick();
        tick();
        @(negedge clk);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        tick();
        @(negedge clk);
        check("live_awready", 32'(awready), 32'd1);
        check("live_wready", 32'(wready), 32'd1);
        check("live_arready", 32'(arready), 32'd1);

        // Simultaneous AW/W write then read back
        write_both(32'h10, 32'hDEADBEEF, 4'hF, ws);
        check("wr10_bresp", 32'(ws), 32'd0);
        @(negedge clk);
        check("b_done_awready", 32'(awready), 32'd1);
        read(32'h10, rd, rs);
        check("rd10_data", rd, 32'hDEADBEEF);
        check("rd10_rresp", 32'(rs), 32'd0);

        // W two cycles ahead of AW
        wvalid = 1'b1; wdata = 32'h11223344; wstrb = 4'hF;
        tick();
        wvalid = 1'b0;
        @(negedge clk);
        check("w_held_wready", 32'(wready), 32'd0);
        check("w_held_awready", 32'(awready), 32'd1);
        check("w_held_nob", 32'(bvalid), 32'd0);
        tick();
        awvalid = 1'b1; awaddr = 32'h20;
        tick();
        awvalid = 1'b0;
        @(negedge clk);
        check("stag_bvalid", 32'(bvalid), 32'd1);
        check("stag_bresp", 32'(bresp), 32'd0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        write_both(32'h20, 32'hAABBCCDD, 4'h5, ws);
        read(32'h20, rd, rs);
        check("rd20_strb", rd, 32'h11BB33DD);

        // wstrb zero leaves word intact
        write_both(32'h10, 32'h0, 4'h0, ws);
        check("strb0_bresp", 32'(ws), 32'd0);
        read(32'h10, rd, rs);
        check("strb0_data", rd, 32'hDEADBEEF);

        // Out-of-range aliasing onto word 0
        write_both(32'h0, 32'hCAFEF00D, 4'hF, ws);
        write_both(32'h400, 32'h55555555, 4'hF, ws);
        check("oor_bresp", 32'(ws), 32'd2);
        read(32'h0, rd, rs);
        check("oor_word0", rd, 32'hCAFEF00D);
        read(32'h400, rd, rs);
        check("oor_rdata", rd, 32'd0);
        check("oor_rresp", 32'(rs), 32'd2);

        // Back-pressure on B and R
        awvalid = 1'b1; awaddr = 32'h50; wvalid = 1'b1; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bstall_bvalid", 32'(bvalid), 32'd1);
            check("bstall_bresp", 32'(bresp), 32'd0);
            check("bstall_awready", 32'(awready), 32'd0);
            check("bstall_wready", 32'(wready), 32'd0);
            tick();
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        @(negedge clk);
        check("bstall_done_b", 32'(bvalid), 32'd0);
        check("bstall_done_aw", 32'(awready), 32'd1);
        arvalid = 1'b1; araddr = 32'h50;
        tick();
        arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rstall_rvalid", 32'(rvalid), 32'd1);
            check("rstall_rdata", rdata, 32'hA5A5A5A5);
            check("rstall_arready", 32'(arready), 32'd0);
            tick();
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        @(negedge clk);
        check("rstall_done_r", 32'(rvalid), 32'd0);
        check("rstall_done_ar", 32'(arready), 32'd1);

        // Same-cycle commit and read of one word
        write_both(32'h30, 32'h1, 4'hF, ws);
        awvalid = 1'b1; awaddr = 32'h30; wvalid = 1'b1; wdata = 32'h2; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 32'h30;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        check("coll_rdata", rdata, 32'h1);
        check("coll_bvalid", 32'(bvalid), 32'd1);
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        read(32'h30, rd, rs);
        check("coll_after", rd, 32'h2);

        // Reset with AW latched and R pending
        write_both(32'h40, 32'h12345678, 4'hF, ws);
        awvalid = 1'b1; awaddr = 32'h40;
        tick();
        awvalid = 1'b0;
        arvalid = 1'b1; araddr = 32'h10;
        tick();
        arvalid = 1'b0;
        @(negedge clk);
        check("pre_rst_rvalid", 32'(rvalid), 32'd1);
        check("pre_rst_awready", 32'(awready), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst2_bvalid", 32'(bvalid), 32'd0);
        check("rst2_rvalid", 32'(rvalid), 32'd0);
        tick();
        @(negedge clk);
        check("rst2_awready", 32'(awready), 32'd1);
        check("rst2_wready", 32'(wready), 32'd1);
        check("rst2_arready", 32'(arready), 32'd1);
        wvalid = 1'b1; wdata = 32'h77777777; wstrb = 4'hF;
        tick();
        wvalid = 1'b0;
        @(negedge clk);
        check("rst2_w_nocommit", 32'(bvalid), 32'd0);
        check("rst2_w_held", 32'(wready), 32'd0);
        read(32'h40, rd, rs);
        check("rst2_word40", rd, 32'h12345678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
